inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Instruction-word builder; the inverse of the decode-side immediate extraction and sign extension.
- Accepts a field-level description of one RV32I instruction (format type, opcode, register indices, funct fields, 32-bit immediate) over a valid/ready handshake.
- Range-checks the immediate, scatters it into the format's bit positions and queues the 32-bit word in an output FIFO.
- Used by the self-test instruction generator feeding the instruction memory writer in sim.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous FIFO clear
- in_valid  input  1  request valid
- in_ready  output  1  request can be accepted
- in_type  input  3  format: 0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal
- in_opcode  input  7  opcode field
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_imm  input  32  immediate: byte offset, or upper value for U
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_inst  output  32  encoded word at head
- out_err  output  1  head entry failed encoding
- err_cnt  output  CNT_W  saturating count of errored entries accepted

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, err_cnt 0, out_valid 0, out_inst 0, out_err 0. in_ready is 0 while rst_n is low.
- in_ready = !flush && (count < DEPTH). Combinational, independent of out_ready; no full-FIFO bypass.
- Push occurs on in_valid && in_ready. The encoded word is written the same edge, so out_valid rises the next cycle. Latency in-to-out is 1 cycle when the FIFO is empty.
- Encoding, bits MSB to LSB:
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Legality checks:
  - I/S: in_imm equals the sign-extension of in_imm[11:0].
  - B: in_imm equals the sign-extension of in_imm[12:0], and in_imm[0]=0.
  - J: in_imm equals the sign-extension of in_imm[20:0], and in_imm[0]=0.
  - U: in_imm[11:0]=0.
  - R: in_imm is ignored and never errors.
  - in_type 6 or 7: always an error.
- Error handling: an illegal entry is still enqueued, with word 32'h0000_0013 (canonical NOP) and err=1. err_cnt increments on that push and saturates at all-ones.
- Pop occurs on out_valid && out_ready. The head advances; out_inst/out_err show the next entry the following cycle.
- Simultaneous push and pop with the FIFO neither full nor empty: count unchanged, both operations take effect. Push into an empty FIFO with out_ready=1 is not visible on the output until the next cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- out_valid = (count != 0). out_inst/out_err are driven from the head register and held stable while out_valid && !out_ready.
- flush: at the next edge, count and pointers return to 0 and out_valid is 0. err_cnt is preserved. in_ready is low in the flush cycle, so no push occurs. A pop in that cycle is irrelevant.
- rst_n asserted mid-stream: all state is cleared immediately. The first push after release behaves as from reset.

Test Plan:
- addi x1,x0,5 (type 1, op 0x13, rd 1, rs1 0, f3 0, imm 5), out_ready=1 -> next cycle out_valid=1, out_inst=0x00500093, out_err=0.
- beq x1,x2,-8 (type 3, op 0x63, rs1 1, rs2 2, f3 0, imm 0xFFFFFFF8) -> 0xFE208CE3. lui x5,0x12345000 (type 4, op 0x37, rd 5) -> 0x123452B7.
- Error cases, each -> out_inst=0x00000013, out_err=1; err_cnt reaches 3:
  - I with imm 2048.
  - B with imm 3.
  - in_type 7.
- Back-pressure: out_ready=0, push 4 distinct words -> in_ready=0 after the 4th; a 5th request is held. Then out_ready=1 -> 4 words drain in order, one per cycle, and the 5th follows.
- Concurrent push and pop at count 2 for 10 cycles -> count stays 2, order preserved across pointer wrap.
- Flush with 3 entries and err_cnt=2 -> out_valid=0 next cycle, err_cnt=2. rst_n pulsed low mid-stream -> out_valid, err_cnt and in_ready go to 0 before the next clk edge.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction-word builder: range-checks and scatters a field-level description
// into a 32-bit word, then queues the word (with an error flag) in a small output FIFO.
module inst_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic        w_legal;
  logic [31:0] w_word;
  logic [31:0] w_enc;
  logic        w_err;

  // An immediate fits N signed bits when every bit from N-1 upward matches.
  assign w_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (in_type)
      TYPE_R: begin
        w_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_legal = 1'b1;
      end
      TYPE_I: begin
        w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_legal = w_fits12;
      end
      TYPE_S: begin
        w_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_legal = w_fits12;
      end
      TYPE_B: begin
        w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        w_legal = w_fits13 & ~in_imm[0];
      end
      TYPE_U: begin
        w_word  = {in_imm[31:12], in_rd, in_opcode};
        w_legal = ~(|in_imm[11:0]);
      end
      TYPE_J: begin
        w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_legal = w_fits21 & ~in_imm[0];
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Illegal requests still occupy a slot so the consumer sees one entry per request.
  assign w_enc = w_legal ? w_word : NOP_WORD;
  assign w_err = ~w_legal;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [32:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_push;
  logic w_pop;

  assign in_ready  = rst_n & ~flush & (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_err, w_enc};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Counts errored entries at enqueue time; survives flush, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push && w_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_inst = r_mem[r_rptr][31:0];
  assign out_err  = r_mem[r_rptr][32];
  assign err_cnt  = r_err_cnt;

endmodule
